// File: rtl/fft16_bfly_sched_if.sv
// Stream-in, butterfly and stream-out signals of the 16-point FFT scheduler.
// master: the scheduler side; slave: the source, butterfly and sink side.
interface fft16_bfly_sched_if #(
   parameter int DW = 24,
   parameter int TW = 32
);
   logic                 in_valid;
   logic                 in_ready;
   logic signed [DW-1:0] in_real;
   logic signed [DW-1:0] in_imag;
   logic signed [DW-1:0] bf_real0;
   logic signed [DW-1:0] bf_imag0;
   logic signed [DW-1:0] bf_real1;
   logic signed [DW-1:0] bf_imag1;
   logic signed [TW-1:0] bf_factor_real;
   logic signed [TW-1:0] bf_factor_imag;
   logic signed [DW-1:0] bf_y0_real;
   logic signed [DW-1:0] bf_y0_imag;
   logic signed [DW-1:0] bf_y1_real;
   logic signed [DW-1:0] bf_y1_imag;
   logic                 out_valid;
   logic                 out_ready;
   logic signed [DW-1:0] out_real;
   logic signed [DW-1:0] out_imag;
   logic [3:0]           out_index;
   logic                 out_last;
   logic                 busy;

   modport master (
      input  in_valid, in_real, in_imag,
      output in_ready,
      output bf_real0, bf_imag0, bf_real1, bf_imag1, bf_factor_real, bf_factor_imag,
      input  bf_y0_real, bf_y0_imag, bf_y1_real, bf_y1_imag,
      output out_valid, out_real, out_imag, out_index, out_last, busy,
      input  out_ready
   );

   modport slave (
      output in_valid, in_real, in_imag,
      input  in_ready,
      input  bf_real0, bf_imag0, bf_real1, bf_imag1, bf_factor_real, bf_factor_imag,
      output bf_y0_real, bf_y0_imag, bf_y1_real, bf_y1_imag,
      input  out_valid, out_real, out_imag, out_index, out_last, busy,
      output out_ready
   );
endinterface

// File: rtl/fft16_bfly_sched.sv
// In-place 16-point radix-2 DIT FFT scheduler: bit-reversed load, 4x8 butterfly issue/writeback, natural-order unload.
// Define FFT16_INVERSE_EN to conjugate the twiddle ROM (inverse transform, unscaled).
module fft16_bfly_sched #(
   parameter int DW       = 24,
   parameter int TW       = 32,
   parameter int BFLY_LAT = 13
) (
   input logic                  clk,
   input logic                  rst,
   fft16_bfly_sched_if.master   io
);

   typedef enum logic [1:0] {S_LOAD, S_ISSUE, S_DRAIN, S_UNLOAD} state_t;

   state_t                        state;
   logic [1:0]                    stage;
   logic [2:0]                    k;
   logic [2:0]                    wb_cnt;
   logic [3:0]                    ld_cnt;
   logic [3:0]                    out_idx;
   logic [3:0]                    cur_a, cur_b;
   logic [BFLY_LAT-1:0]           dl_v;
   logic [BFLY_LAT-1:0][3:0]      dl_a, dl_b;

   logic signed [DW-1:0]          mem_re [16];
   logic signed [DW-1:0]          mem_im [16];
   logic signed [DW-1:0]          rd_re  [16];
   logic signed [DW-1:0]          rd_im  [16];

   logic                          in_ready_q, out_valid_q, out_last_q;
   logic signed [DW-1:0]          out_re_q, out_im_q;
   logic signed [DW-1:0]          bf_r0_q, bf_i0_q, bf_r1_q, bf_i1_q;
   logic signed [TW-1:0]          bf_wr_q, bf_wi_q;

   logic                          accept, wb_v, wb_last, nxt_go;
   logic [3:0]                    wb_a, wb_b, nxt_a, nxt_b;
   logic [1:0]                    nxt_s;
   logic [2:0]                    nxt_k, nxt_m, nxt_mask;

   function automatic logic signed [TW-1:0] tw_re(input logic [2:0] m);
      case (m)
         3'd0:    return TW'(8192);
         3'd1:    return TW'(7568);
         3'd2:    return TW'(5793);
         3'd3:    return TW'(3135);
         3'd4:    return TW'(0);
         3'd5:    return TW'(-3135);
         3'd6:    return TW'(-5793);
         default: return TW'(-7568);
      endcase
   endfunction

   function automatic logic signed [TW-1:0] tw_im(input logic [2:0] m);
      logic signed [TW-1:0] v;
      case (m)
         3'd0:    v = TW'(0);
         3'd1:    v = TW'(-3135);
         3'd2:    v = TW'(-5793);
         3'd3:    v = TW'(-7568);
         3'd4:    v = TW'(-8192);
         3'd5:    v = TW'(-7568);
         3'd6:    v = TW'(-5793);
         default: v = TW'(-3135);
      endcase
`ifdef FFT16_INVERSE_EN
      return -v;
`else
      return v;
`endif
   endfunction

   function automatic logic [3:0] bitrev4(input logic [3:0] n);
      return {n[0], n[1], n[2], n[3]};
   endfunction

   assign accept  = io.in_valid & in_ready_q;
   assign wb_v    = dl_v[BFLY_LAT-1];
   assign wb_a    = dl_a[BFLY_LAT-1];
   assign wb_b    = dl_b[BFLY_LAT-1];
   assign wb_last = wb_v && (wb_cnt == 3'd7);

   // Reads forward the writeback landing on the same edge, so the first
   // butterfly of the next stage sees the final result of the previous one.
   always_comb begin
      for (int unsigned i = 0; i < 16; i++) begin
         rd_re[i] = mem_re[i];
         rd_im[i] = mem_im[i];
         if (wb_v && wb_a == 4'(i)) begin
            rd_re[i] = io.bf_y0_real;
            rd_im[i] = io.bf_y0_imag;
         end
         if (wb_v && wb_b == 4'(i)) begin
            rd_re[i] = io.bf_y1_real;
            rd_im[i] = io.bf_y1_imag;
         end
      end
   end

   // Butterfly to be presented in the next cycle (operands are registered).
   always_comb begin
      nxt_go = 1'b0;
      nxt_s  = stage;
      nxt_k  = '0;
      case (state)
         S_LOAD:  if (accept && ld_cnt == 4'd15) begin
                     nxt_go = 1'b1;
                     nxt_s  = '0;
                  end
         S_ISSUE: if (k != 3'd7) begin
                     nxt_go = 1'b1;
                     nxt_k  = k + 3'd1;
                  end
         S_DRAIN: if (wb_last && stage != 2'd3) begin
                     nxt_go = 1'b1;
                     nxt_s  = stage + 2'd1;
                  end
         default: ;
      endcase
      nxt_mask = (3'd1 << nxt_s) - 3'd1;
      nxt_a    = (({1'b0, nxt_k} >> nxt_s) << ({1'b0, nxt_s} + 3'd1)) | {1'b0, nxt_k & nxt_mask};
      nxt_b    = nxt_a | (4'd1 << nxt_s);
      nxt_m    = (nxt_k & nxt_mask) << (2'd3 - nxt_s);
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         mem_re[bitrev4(ld_cnt)] <= io.in_real;
         mem_im[bitrev4(ld_cnt)] <= io.in_imag;
      end
      if (wb_v) begin
         mem_re[wb_a] <= io.bf_y0_real;
         mem_im[wb_a] <= io.bf_y0_imag;
         mem_re[wb_b] <= io.bf_y1_real;
         mem_im[wb_b] <= io.bf_y1_imag;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_LOAD;
         stage       <= '0;
         k           <= '0;
         wb_cnt      <= '0;
         ld_cnt      <= '0;
         out_idx     <= '0;
         cur_a       <= '0;
         cur_b       <= '0;
         dl_v        <= '0;
         dl_a        <= '0;
         dl_b        <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_re_q    <= '0;
         out_im_q    <= '0;
         bf_r0_q     <= '0;
         bf_i0_q     <= '0;
         bf_r1_q     <= '0;
         bf_i1_q     <= '0;
         bf_wr_q     <= '0;
         bf_wi_q     <= '0;
      end else begin
         dl_v <= {dl_v[BFLY_LAT-2:0], state == S_ISSUE};
         dl_a <= {dl_a[BFLY_LAT-2:0], cur_a};
         dl_b <= {dl_b[BFLY_LAT-2:0], cur_b};
         if (wb_v) wb_cnt <= wb_cnt + 3'd1;

         if (nxt_go) begin
            cur_a   <= nxt_a;
            cur_b   <= nxt_b;
            bf_r0_q <= rd_re[nxt_a];
            bf_i0_q <= rd_im[nxt_a];
            bf_r1_q <= rd_re[nxt_b];
            bf_i1_q <= rd_im[nxt_b];
            bf_wr_q <= tw_re(nxt_m);
            bf_wi_q <= tw_im(nxt_m);
         end else begin
            bf_r0_q <= '0;
            bf_i0_q <= '0;
            bf_r1_q <= '0;
            bf_i1_q <= '0;
            bf_wr_q <= '0;
            bf_wi_q <= '0;
         end

         case (state)
            S_LOAD: begin
               in_ready_q <= 1'b1;
               if (accept) begin
                  ld_cnt <= ld_cnt + 4'd1;
                  if (ld_cnt == 4'd15) begin
                     state      <= S_ISSUE;
                     stage      <= '0;
                     k          <= '0;
                     in_ready_q <= 1'b0;
                  end
               end
            end
            S_ISSUE: begin
               k <= k + 3'd1;
               if (k == 3'd7) state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (wb_last) begin
                  if (stage == 2'd3) begin
                     state       <= S_UNLOAD;
                     out_valid_q <= 1'b1;
                     out_idx     <= '0;
                     out_last_q  <= 1'b0;
                     out_re_q    <= rd_re[0];
                     out_im_q    <= rd_im[0];
                  end else begin
                     stage <= stage + 2'd1;
                     state <= S_ISSUE;
                  end
               end
            end
            S_UNLOAD: begin
               if (io.out_ready) begin
                  if (out_idx == 4'd15) begin
                     state       <= S_LOAD;
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     out_idx     <= '0;
                     out_re_q    <= '0;
                     out_im_q    <= '0;
                     in_ready_q  <= 1'b1;
                  end else begin
                     out_idx    <= out_idx + 4'd1;
                     out_re_q   <= rd_re[out_idx + 4'd1];
                     out_im_q   <= rd_im[out_idx + 4'd1];
                     out_last_q <= (out_idx == 4'd14);
                  end
               end
            end
            default: state <= S_LOAD;
         endcase
      end
   end

   assign io.in_ready       = in_ready_q;
   assign io.bf_real0       = bf_r0_q;
   assign io.bf_imag0       = bf_i0_q;
   assign io.bf_real1       = bf_r1_q;
   assign io.bf_imag1       = bf_i1_q;
   assign io.bf_factor_real = bf_wr_q;
   assign io.bf_factor_imag = bf_wi_q;
   assign io.out_valid      = out_valid_q;
   assign io.out_real       = out_re_q;
   assign io.out_imag       = out_im_q;
   assign io.out_index      = out_idx;
   assign io.out_last       = out_last_q;
   assign io.busy           = (state != S_LOAD);

endmodule

// File: tb/tb_fft16_bfly_sched.sv
// Bench for fft16_bfly_sched: models the butter_2 pipeline and checks frames against an array-based FFT reference.
module tb_fft16_bfly_sched;
   localparam int DW  = 24;
   localparam int TW  = 32;
   localparam int LAT = 13;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fft16_bfly_sched_if #(.DW(DW), .TW(TW)) bus ();
   fft16_bfly_sched #(.DW(DW), .TW(TW), .BFLY_LAT(LAT)) dut (.clk(clk), .rst(rst), .io(bus));

   int checks = 0;
   int errors = 0;
   int unsigned cyc = 0;
   int unsigned t_acc = 0;
   int used = 0;
   always @(posedge clk) cyc <= cyc + 1;

   longint rom_r [8] = '{8192, 7568, 5793, 3135, 0, -3135, -5793, -7568};
   longint rom_i [8] = '{0, -3135, -5793, -7568, -8192, -7568, -5793, -3135};
   longint cosq  [16] = '{4096, 3784, 2896, 1567, 0, -1567, -2896, -3784,
                          -4096, -3784, -2896, -1567, 0, 1567, 2896, 3784};
   longint fr [16], fi [16], er [16], ei [16];

   function automatic longint tw_i(input int m);
`ifdef FFT16_INVERSE_EN
      return -rom_i[m];
`else
      return rom_i[m];
`endif
   endfunction

   function automatic longint rmul(input longint p);
      return (p + 64'sd4096) >>> 13;
   endfunction

   function automatic longint wrap(input longint v);
      logic signed [DW-1:0] t;
      t = v[DW-1:0];
      return longint'(t);
   endfunction

   function automatic int bitrev(input int n);
      return ((n & 1) << 3) | ((n & 2) << 1) | ((n & 4) >> 1) | ((n & 8) >> 3);
   endfunction

   // butter_2 model: y0 = x0 + W*x1, y1 = x0 - W*x1, product rounded at 2^13.
   logic signed [DW-1:0] p0r [LAT], p0i [LAT], p1r [LAT], p1i [LAT];
   longint bt_r, bt_i;
   always @(posedge clk) begin
      bt_r = rmul(longint'(bus.bf_real1) * bus.bf_factor_real - longint'(bus.bf_imag1) * bus.bf_factor_imag);
      bt_i = rmul(longint'(bus.bf_real1) * bus.bf_factor_imag + longint'(bus.bf_imag1) * bus.bf_factor_real);
      for (int i = LAT - 1; i > 0; i--) begin
         p0r[i] <= p0r[i-1];
         p0i[i] <= p0i[i-1];
         p1r[i] <= p1r[i-1];
         p1i[i] <= p1i[i-1];
      end
      p0r[0] <= DW'(longint'(bus.bf_real0) + bt_r);
      p0i[0] <= DW'(longint'(bus.bf_imag0) + bt_i);
      p1r[0] <= DW'(longint'(bus.bf_real0) - bt_r);
      p1i[0] <= DW'(longint'(bus.bf_imag0) - bt_i);
   end
   assign bus.bf_y0_real = p0r[LAT-1];
   assign bus.bf_y0_imag = p0i[LAT-1];
   assign bus.bf_y1_real = p1r[LAT-1];
   assign bus.bf_y1_imag = p1i[LAT-1];

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_tol(input string tag, input logic signed [63:0] obs, input longint exp, input longint tol);
      logic ok;
      ok = (obs >= exp - tol) && (obs <= exp + tol);
      checks++;
      assert (ok === 1'b1) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d+-%0d", tag, obs, exp, tol);
      end
   endtask

   // Textbook in-place DIT FFT over plain arrays, same butterfly arithmetic.
   task automatic compute_ref();
      longint ar [16], ai [16];
      longint tr, ti, ur, ui;
      for (int n = 0; n < 16; n++) begin
         ar[bitrev(n)] = fr[n];
         ai[bitrev(n)] = fi[n];
      end
      for (int len = 2; len <= 16; len = len * 2)
         for (int base = 0; base < 16; base += len)
            for (int j = 0; j < len / 2; j++) begin
               int m, p, q;
               m  = j * (16 / len);
               p  = base + j;
               q  = p + len / 2;
               tr = rmul(ar[q] * rom_r[m] - ai[q] * tw_i(m));
               ti = rmul(ar[q] * tw_i(m) + ai[q] * rom_r[m]);
               ur = ar[p];
               ui = ai[p];
               ar[p] = wrap(ur + tr);
               ai[p] = wrap(ui + ti);
               ar[q] = wrap(ur - tr);
               ai[q] = wrap(ui - ti);
            end
      for (int n = 0; n < 16; n++) begin
         er[n] = ar[n];
         ei[n] = ai[n];
      end
   endtask

   task automatic send_frame(input bit keep_valid);
      int  n = 0;
      logic acc;
      used = 0;
      while (n < 16 && used < 200) begin
         @(negedge clk);
         used++;
         bus.in_valid = 1'b1;
         bus.in_real  = DW'(fr[n]);
         bus.in_imag  = DW'(fi[n]);
         acc = bus.in_ready;
         @(posedge clk);
         if (acc) n++;
      end
      if (n < 16) chk("send_timeout", n, 16);
      @(negedge clk);
      t_acc = cyc;
      chk("in_ready_drop", bus.in_ready, 0);
      if (keep_valid) begin
         bus.in_real = DW'($urandom);
         bus.in_imag = DW'($urandom);
      end else begin
         bus.in_valid = 1'b0;
      end
   endtask

   task automatic receive_frame(input bit rand_ready, input longint tol);
      int   idx = 0;
      int   guard = 0;
      logic stalled = 1'b0;
      logic rdy;
      logic signed [DW-1:0] sr, si;
      logic [3:0] sx;
      while (idx < 16 && guard < 3000) begin
         @(negedge clk);
         guard++;
         if (stalled) begin
            chk("stall_real", bus.out_real, sr);
            chk("stall_imag", bus.out_imag, si);
            chk("stall_index", bus.out_index, sx);
            chk("stall_valid", bus.out_valid, 1);
         end
         rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.out_ready = rdy;
         stalled = 1'b0;
         if (bus.out_valid) begin
            if (rdy) begin
               chk("bin_index", bus.out_index, idx);
               chk("bin_last", bus.out_last, (idx == 15));
               if (tol == 0) begin
                  chk("bin_real", bus.out_real, er[idx]);
                  chk("bin_imag", bus.out_imag, ei[idx]);
               end else begin
                  chk_tol("bin_real_tol", bus.out_real, er[idx], tol);
                  chk_tol("bin_imag_tol", bus.out_imag, ei[idx], tol);
               end
               idx++;
            end else begin
               stalled = 1'b1;
               sr = bus.out_real;
               si = bus.out_imag;
               sx = bus.out_index;
            end
         end
      end
      if (idx < 16) chk("recv_timeout", idx, 16);
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk("in_ready_after_last", bus.in_ready, 1);
      chk("out_valid_after_last", bus.out_valid, 0);
   endtask

   task automatic set_impulse();
      for (int n = 0; n < 16; n++) begin
         fr[n] = (n == 0) ? 1000 : 0;
         fi[n] = 0;
         er[n] = 1000;
         ei[n] = 0;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, bus.in_ready, 0);
      chk({tag, "_out_valid"}, bus.out_valid, 0);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_out_last"}, bus.out_last, 0);
      chk({tag, "_out_index"}, bus.out_index, 0);
      chk({tag, "_bf_real0"}, bus.bf_real0, 0);
      chk({tag, "_bf_imag1"}, bus.bf_imag1, 0);
      chk({tag, "_bf_factor_real"}, bus.bf_factor_real, 0);
   endtask

   initial begin
      int tone_bin;
      int guard;
`ifdef FFT16_INVERSE_EN
      tone_bin = 15;
`else
      tone_bin = 1;
`endif
      bus.in_valid  = 1'b0;
      bus.in_real   = '0;
      bus.in_imag   = '0;
      bus.out_ready = 1'b0;

      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      @(negedge clk);
      chk("in_ready_after_release", bus.in_ready, 1);
      chk("busy_after_release", bus.busy, 0);

      // Impulse frame with continuous in_valid: timing of issue and unload.
      set_impulse();
      send_frame(1'b1);
      chk("accepts_contiguous", used, 16);
      chk("busy_issue", bus.busy, 1);
      chk("stage0_first_op0", bus.bf_real0, 1000);
      chk("stage0_first_op1", bus.bf_real1, 0);
      for (int i = 0; i < 8; i++) begin
         chk("stage0_factor_real", bus.bf_factor_real, 8192);
         chk("stage0_factor_imag", bus.bf_factor_imag, 0);
         @(negedge clk);
      end
      chk("bf_idle_factor", bus.bf_factor_real, 0);
      chk("bf_idle_op0", bus.bf_real0, 0);
      chk("in_ready_ignored_valid", bus.in_ready, 0);
      bus.in_valid = 1'b0;
      guard = 0;
      while (!bus.out_valid && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      chk("out_valid_latency", longint'(cyc) - longint'(t_acc) + 1, 85);
      receive_frame(1'b0, 0);

      // DC frame.
      for (int n = 0; n < 16; n++) begin
         fr[n] = 100;
         fi[n] = 0;
         er[n] = (n == 0) ? 1600 : 0;
         ei[n] = 0;
      end
      send_frame(1'b0);
      receive_frame(1'b0, 4);

      // Tone at bin 1 (bin 15 for the inverse transform).
      for (int n = 0; n < 16; n++) begin
         fr[n] = cosq[n];
         fi[n] = cosq[(n + 12) % 16];
         er[n] = (n == tone_bin) ? 65536 : 0;
         ei[n] = 0;
      end
      send_frame(1'b0);
      receive_frame(1'b0, 8);

      // Random frames, random backpressure, back-to-back.
      for (int f = 0; f < 3; f++) begin
         for (int n = 0; n < 16; n++) begin
            fr[n] = longint'($urandom_range(0, 262143)) - 131072;
            fi[n] = longint'($urandom_range(0, 262143)) - 131072;
         end
         compute_ref();
         send_frame(1'b0);
         receive_frame(1'b1, 0);
      end

      // Reset in the middle of stage 2 DRAIN.
      for (int n = 0; n < 16; n++) begin
         fr[n] = longint'($urandom_range(0, 65535)) - 32768;
         fi[n] = longint'($urandom_range(0, 65535)) - 32768;
      end
      send_frame(1'b0);
      while (cyc < t_acc + 55) @(negedge clk);
      chk("midrun_busy", bus.busy, 1);
      chk("stage2_drain_idle_bf", bus.bf_real0, 0);
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("midreset");
      rst = 1'b0;
      @(negedge clk);
      chk("in_ready_after_midreset", bus.in_ready, 1);
      set_impulse();
      send_frame(1'b0);
      receive_frame(1'b1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
